tophat_forest_core: RTL and testbench



---
 rtl/tophat_forest_core.sv | 211 +++++++++++++++++++++
 tb/tb_tophat_forest_core.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tophat_forest_core.sv
// Sequential decision-forest evaluator: walks each tree one node per cycle,
// accumulates the signed leaf values and reports saturated and full-width sums.
module tophat_forest_core #(
    parameter int unsigned NUM_FEATURES = 8,
    parameter int unsigned NUM_TREES    = 4,
    parameter int unsigned NUM_INTERNAL = 7,
    parameter int unsigned NUM_LEAVES   = 8,
    parameter int unsigned FEAT_W       = 8,
    parameter int unsigned LEAF_W       = 8,
    parameter int unsigned ACC_W        = 12,
    parameter int unsigned MAX_DEPTH    = 8,
    localparam int unsigned FIDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1,
    localparam int unsigned IDX_W  = $clog2(NUM_INTERNAL + NUM_LEAVES)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   clear_i,
    input  logic                                   run_i,
    input  logic                                   model_loaded_i,
    input  logic                                   features_loaded_i,
    input  logic [NUM_FEATURES*FEAT_W-1:0]         feature_vector_i,
    input  logic [NUM_TREES*NUM_INTERNAL*FIDX_W-1:0] node_feature_i,
    input  logic [NUM_TREES*NUM_INTERNAL*FEAT_W-1:0] node_threshold_i,
    input  logic [NUM_TREES*NUM_INTERNAL*IDX_W-1:0]  node_left_i,
    input  logic [NUM_TREES*NUM_INTERNAL*IDX_W-1:0]  node_right_i,
    input  logic [NUM_TREES*NUM_LEAVES*LEAF_W-1:0]   leaf_value_i,
    output logic                                   busy_o,
    output logic                                   pred_valid_o,
    output logic [LEAF_W-1:0]                      pred_value_o,
    output logic [ACC_W-1:0]                       pred_sum_o,
    output logic                                   error_o
);

    localparam int unsigned TREE_W    = (NUM_TREES > 1) ? $clog2(NUM_TREES) : 1;
    localparam int unsigned DEPTH_W   = $clog2(MAX_DEPTH + 1);
    localparam int unsigned NUM_FSLOT = 2 ** FIDX_W;
    localparam int unsigned NUM_CSLOT = 2 ** IDX_W;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WALK = 1'b1;

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (LEAF_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (LEAF_W - 1)));

    logic [0:0]               state_q, state_d;
    logic [TREE_W-1:0]        tree_q, tree_d;
    logic [IDX_W-1:0]         node_q, node_d;
    logic [DEPTH_W-1:0]       depth_q, depth_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     busy_q, busy_d;
    logic                     valid_q, valid_d;
    logic [LEAF_W-1:0]        value_q, value_d;
    logic [ACC_W-1:0]         sum_q, sum_d;
    logic                     error_q, error_d;

    logic [NUM_FSLOT-1:0]     feat_ok;
    logic [NUM_CSLOT-1:0]     child_int;
    logic [NUM_CSLOT-1:0]     child_leaf;
    int unsigned              ent;
    int unsigned              lidx;
    logic [FIDX_W-1:0]        fsel;
    logic [FEAT_W-1:0]        fval;
    logic [FEAT_W-1:0]        thr;
    logic [IDX_W-1:0]         child;
    logic signed [LEAF_W-1:0] leaf_val;
    logic signed [ACC_W-1:0]  acc_sum;
    logic [LEAF_W-1:0]        sat_val;

    // Constant decode tables: which feature selects and child indices are legal
    always_comb begin
        feat_ok    = '0;
        child_int  = '0;
        child_leaf = '0;
        for (int unsigned i = 0; i < NUM_FSLOT; i++) begin
            feat_ok[i] = (i < NUM_FEATURES);
        end
        for (int unsigned i = 0; i < NUM_CSLOT; i++) begin
            child_int[i]  = (i < NUM_INTERNAL);
            child_leaf[i] = (i >= NUM_INTERNAL) && (i < NUM_INTERNAL + NUM_LEAVES);
        end
    end

    // Current-node lookup, comparison, leaf fetch and saturation
    always_comb begin
        ent      = 32'(tree_q) * NUM_INTERNAL + 32'(node_q);
        fsel     = node_feature_i[ent*FIDX_W +: FIDX_W];
        thr      = node_threshold_i[ent*FEAT_W +: FEAT_W];
        fval     = feature_vector_i[32'(fsel)*FEAT_W +: FEAT_W];
        child    = (fval <= thr) ? node_left_i[ent*IDX_W +: IDX_W]
                                 : node_right_i[ent*IDX_W +: IDX_W];
        lidx     = child_leaf[child] ? (32'(child) - NUM_INTERNAL) : 32'd0;
        leaf_val = leaf_value_i[(32'(tree_q) * NUM_LEAVES + lidx)*LEAF_W +: LEAF_W];
        acc_sum  = acc_q + ACC_W'(leaf_val);
        if (acc_sum > SAT_HI) begin
            sat_val = {1'b0, {(LEAF_W-1){1'b1}}};
        end else if (acc_sum < SAT_LO) begin
            sat_val = {1'b1, {(LEAF_W-1){1'b0}}};
        end else begin
            sat_val = LEAF_W'(acc_sum);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        tree_d  = tree_q;
        node_d  = node_q;
        depth_d = depth_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        value_d = value_q;
        sum_d   = sum_q;
        error_d = error_q;

        if (clear_i) begin
            state_d = S_IDLE;
            tree_d  = '0;
            node_d  = '0;
            depth_d = '0;
            acc_d   = '0;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            value_d = '0;
            sum_d   = '0;
            error_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run_i) begin
                        valid_d = 1'b0;
                        if (model_loaded_i && features_loaded_i) begin
                            state_d = S_WALK;
                            busy_d  = 1'b1;
                            tree_d  = '0;
                            node_d  = '0;
                            depth_d = '0;
                            acc_d   = '0;
                            error_d = 1'b0;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
                S_WALK: begin
                    if (!feat_ok[fsel] || !(child_int[child] || child_leaf[child]) ||
                        (child_int[child] && depth_q == DEPTH_W'(MAX_DEPTH - 1))) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        valid_d = 1'b0;
                        error_d = 1'b1;
                    end else if (child_int[child]) begin
                        node_d  = child;
                        depth_d = depth_q + DEPTH_W'(1);
                    end else begin
                        acc_d = acc_sum;
                        if (tree_q == TREE_W'(NUM_TREES - 1)) begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            valid_d = 1'b1;
                            sum_d   = acc_sum;
                            value_d = sat_val;
                        end else begin
                            tree_d  = tree_q + TREE_W'(1);
                            node_d  = '0;
                            depth_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tree_q  <= '0;
            node_q  <= '0;
            depth_q <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            value_q <= '0;
            sum_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tree_q  <= tree_d;
            node_q  <= node_d;
            depth_q <= depth_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            value_q <= value_d;
            sum_q   <= sum_d;
            error_q <= error_d;
        end
    end

    assign busy_o       = busy_q;
    assign pred_valid_o = valid_q;
    assign pred_value_o = value_q;
    assign pred_sum_o   = sum_q;
    assign error_o      = error_q;

endmodule

// File: tb/tb_tophat_forest_core.sv
// Directed bench for tophat_forest_core: default 4-tree instance plus an 8-tree instance.
module tb_tophat_forest_core;

    localparam int unsigned NF  = 8;
    localparam int unsigned NT  = 4;
    localparam int unsigned NT8 = 8;
    localparam int unsigned NI  = 7;
    localparam int unsigned NL  = 8;
    localparam int unsigned FW  = 8;
    localparam int unsigned LW  = 8;
    localparam int unsigned AW  = 12;
    localparam int unsigned FXW = 3;
    localparam int unsigned IXW = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic clear, run, run8, model_ld, feat_ld;
    logic [NF*FW-1:0]      fvec;
    logic [NT*NI*FXW-1:0]  nfeat;
    logic [NT*NI*FW-1:0]   nthr;
    logic [NT*NI*IXW-1:0]  nleft, nright;
    logic [NT*NL*LW-1:0]   leaf;
    logic [NT8*NI*FXW-1:0] nfeat8;
    logic [NT8*NI*FW-1:0]  nthr8;
    logic [NT8*NI*IXW-1:0] nleft8, nright8;
    logic [NT8*NL*LW-1:0]  leaf8;

    logic          busy, valid, err;
    logic [LW-1:0] value;
    logic [AW-1:0] sum;
    logic          busy8, valid8, err8;
    logic [LW-1:0] value8;
    logic [AW-1:0] sum8;

    int total = 0;
    int bad   = 0;
    int cyc;

    always #5 clk = ~clk;

    tophat_forest_core #(.NUM_TREES(NT), .ACC_W(AW)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .run_i(run),
        .model_loaded_i(model_ld), .features_loaded_i(feat_ld),
        .feature_vector_i(fvec), .node_feature_i(nfeat), .node_threshold_i(nthr),
        .node_left_i(nleft), .node_right_i(nright), .leaf_value_i(leaf),
        .busy_o(busy), .pred_valid_o(valid), .pred_value_o(value),
        .pred_sum_o(sum), .error_o(err)
    );

    tophat_forest_core #(.NUM_TREES(NT8), .ACC_W(AW)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .run_i(run8),
        .model_loaded_i(model_ld), .features_loaded_i(feat_ld),
        .feature_vector_i(fvec), .node_feature_i(nfeat8), .node_threshold_i(nthr8),
        .node_left_i(nleft8), .node_right_i(nright8), .leaf_value_i(leaf8),
        .busy_o(busy8), .pred_valid_o(valid8), .pred_value_o(value8),
        .pred_sum_o(sum8), .error_o(err8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Complete depth-3 trees: node n tests feature n against 0x80, children 2n+1 / 2n+2
    task automatic build(input logic [7:0] l0, input logic [7:0] l7);
        for (int t = 0; t < NT8; t++) begin
            for (int n = 0; n < NI; n++) begin
                if (t < NT) begin
                    nfeat[(t*NI+n)*FXW +: FXW]  = 3'(n);
                    nthr[(t*NI+n)*FW +: FW]     = 8'h80;
                    nleft[(t*NI+n)*IXW +: IXW]  = 4'(2*n+1);
                    nright[(t*NI+n)*IXW +: IXW] = 4'(2*n+2);
                end
                nfeat8[(t*NI+n)*FXW +: FXW]  = 3'(n);
                nthr8[(t*NI+n)*FW +: FW]     = 8'h80;
                nleft8[(t*NI+n)*IXW +: IXW]  = 4'(2*n+1);
                nright8[(t*NI+n)*IXW +: IXW] = 4'(2*n+2);
            end
            for (int l = 0; l < NL; l++) begin
                if (t < NT) leaf[(t*NL+l)*LW +: LW] = (l == 0) ? l0 : (l == 7) ? l7 : 8'h00;
                leaf8[(t*NL+l)*LW +: LW] = (l == 0) ? l0 : (l == 7) ? l7 : 8'h00;
            end
        end
    endtask

    // Pulse run and count busy cycles; optionally keep run high while busy
    task automatic run_walk(input bit poke, output int cycles);
        run = 1'b1;
        step();
        run = poke;
        cycles = 0;
        while (busy === 1'b1 && cycles < 200) begin
            cycles++;
            step();
        end
        run = 1'b0;
    endtask

    task automatic run_walk8(output int cycles);
        run8 = 1'b1;
        step();
        run8 = 1'b0;
        cycles = 0;
        while (busy8 === 1'b1 && cycles < 400) begin
            cycles++;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; run = 1'b0; run8 = 1'b0;
        model_ld = 1'b1; feat_ld = 1'b1;
        fvec = '0;
        build(8'd10, 8'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_value", 32'(value), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_error", 32'(err), 32'd0);

        // Basic walk: every tree ends at leaf0=10
        run_walk(1'b0, cyc);
        check("s1_cycles", 32'(cyc), 32'd12);
        check("s1_valid", 32'(valid), 32'd1);
        check("s1_value", 32'(value), 32'h28);
        check("s1_sum", 32'(sum), 32'h028);
        check("s1_error", 32'(err), 32'd0);

        // All right: leaf7=-3 in each tree
        build(8'd10, 8'hFD);
        fvec = {NF{8'hFF}};
        run_walk(1'b0, cyc);
        check("neg_cycles", 32'(cyc), 32'd12);
        check("neg_value", 32'(value), 32'hF4);
        check("neg_sum", 32'(sum), 32'hFF4);

        // Positive saturation
        build(8'd100, 8'd0);
        fvec = '0;
        run_walk(1'b0, cyc);
        check("pos_sat_sum", 32'(sum), 32'h190);
        check("pos_sat_value", 32'(value), 32'h7F);

        // Negative saturation (-100 = 0x9C)
        build(8'h9C, 8'd0);
        run_walk(1'b0, cyc);
        check("neg_sat_sum", 32'(sum), 32'hE70);
        check("neg_sat_value", 32'(value), 32'h80);
        check("neg_sat_valid", 32'(valid), 32'd1);

        // Run with features not loaded
        feat_ld = 1'b0;
        run = 1'b1;
        step();
        run = 1'b0;
        check("noload_error", 32'(err), 32'd1);
        check("noload_busy", 32'(busy), 32'd0);
        check("noload_valid", 32'(valid), 32'd0);
        step();
        check("noload_busy_hold", 32'(busy), 32'd0);
        check("noload_error_sticky", 32'(err), 32'd1);
        feat_ld = 1'b1;
        build(8'd10, 8'd0);
        run_walk(1'b0, cyc);
        check("recover_error", 32'(err), 32'd0);
        check("recover_cycles", 32'(cyc), 32'd12);
        check("recover_value", 32'(value), 32'h28);

        // Out-of-range child in tree 2 node 0
        nleft[(2*NI)*IXW +: IXW] = 4'd15;
        run_walk(1'b0, cyc);
        check("badchild_cycles", 32'(cyc), 32'd7);
        check("badchild_error", 32'(err), 32'd1);
        check("badchild_valid", 32'(valid), 32'd0);

        // Self loop in tree 2 node 0 trips the depth guard
        nleft[(2*NI)*IXW +: IXW] = 4'd0;
        run_walk(1'b0, cyc);
        check("loop_cycles", 32'(cyc), 32'd14);
        check("loop_error", 32'(err), 32'd1);
        check("loop_valid", 32'(valid), 32'd0);
        build(8'd10, 8'd0);

        // Clear on busy cycle 5
        run = 1'b1;
        step();
        run = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("clr_busy_before", 32'(busy), 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_valid", 32'(valid), 32'd0);
        check("clr_value", 32'(value), 32'd0);
        check("clr_sum", 32'(sum), 32'd0);
        check("clr_error", 32'(err), 32'd0);

        // Clear wins over a simultaneous run
        run = 1'b1;
        clear = 1'b1;
        step();
        run = 1'b0;
        clear = 1'b0;
        check("clr_run_busy", 32'(busy), 32'd0);
        step();
        check("clr_run_busy_later", 32'(busy), 32'd0);

        // Run held high during the walk is ignored
        run_walk(1'b1, cyc);
        check("poke_cycles", 32'(cyc), 32'd12);
        check("poke_valid", 32'(valid), 32'd1);
        check("poke_value", 32'(value), 32'h28);
        check("poke_sum", 32'(sum), 32'h028);

        // Eight-tree instance: 8 x 100 = 800
        build(8'd100, 8'd0);
        run_walk8(cyc);
        check("t8_cycles", 32'(cyc), 32'd24);
        check("t8_valid", 32'(valid8), 32'd1);
        check("t8_sum", 32'(sum8), 32'h320);
        check("t8_value", 32'(value8), 32'h7F);
        check("t8_error", 32'(err8), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
